// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the default operand width, the FSM state encoding, the iteration
// count and the fill value driven on overflow / divide-by-zero.
package divisor_pkg;

  localparam int unsigned N_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    SUB   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // One SHIFT/SUB pair per quotient bit.
  localparam int unsigned ITER = N_DEF;

  localparam logic [N_DEF-1:0] OVF_FILL = '1;

endpackage

// File: rtl/divisor_passo.sv
// Combinational restoring-division step: trial subtract of the divisor from
// the (N+1)-bit partial remainder.
// Ports:
//   rem  - partial remainder including the shifted-out carry (N+1 bits)
//   b    - divisor (N bits)
//   diff - rem - b (N+1 bits), meaningful when ge is set
//   ge   - 1 when rem >= b, i.e. the quotient bit is 1
module divisor_passo
  import divisor_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic [N:0]   rem,
  input  logic [N-1:0] b,
  output logic [N:0]   diff,
  output logic         ge
);

  logic [N:0] b_ext;

  assign b_ext = {1'b0, b};
  assign ge    = (rem >= b_ext);
  assign diff  = rem - b_ext;

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential unsigned restoring divider: 2N-bit Dividendo / N-bit Divisor.
// Frames are started and chained by the Sy level, matching the shift-add
// multiplier's control scheme. A frame is LOAD, N x (SHIFT, SUB), DONE.
// Ports:
//   Clk       - rising-edge clock
//   Reset     - synchronous active-high reset (aborts a frame in flight)
//   Sy        - start level; while high, frames run back to back
//   Dividendo - dividend, latched at the end of LOAD
//   Divisor   - divisor, latched at the end of LOAD
//   Quociente - registered quotient of the last completed frame
//   Resto     - registered remainder of the last completed frame
//   Erro      - registered overflow / divide-by-zero flag
//   Pronto    - one-cycle pulse after new results are written
module divisor_sequencial
  import divisor_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Sy,
  input  logic [2*N-1:0] Dividendo,
  input  logic [N-1:0]   Divisor,
  output logic [N-1:0]   Quociente,
  output logic [N-1:0]   Resto,
  output logic           Erro,
  output logic           Pronto
);

  localparam logic [5:0]   LAST = 6'(N - 1);
  localparam logic [N-1:0] FILL = '1;

  state_t       state;
  state_t       state_next;
  logic [5:0]   counter;
  // {carry, remainder, quotient}; quotient bits enter at bit 0 as the
  // dividend shifts out into the remainder half.
  logic [2*N:0] rq;
  logic [N-1:0] b;
  logic         ovf;

  logic [N:0]   step_diff;
  logic         step_ge;

  divisor_passo #(
    .N(N)
  ) u_passo (
    .rem  (rq[2*N:N]),
    .b    (b),
    .diff (step_diff),
    .ge   (step_ge)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Sy) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   state_next = SUB;
      SUB:     state_next = (counter == LAST) ? DONE : SHIFT;
      DONE:    state_next = Sy ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      counter   <= '0;
      rq        <= '0;
      b         <= '0;
      ovf       <= 1'b0;
      Quociente <= '0;
      Resto     <= '0;
      Erro      <= 1'b0;
      Pronto    <= 1'b0;
    end else begin
      state  <= state_next;
      Pronto <= 1'b0;
      case (state)
        LOAD: begin
          rq      <= {1'b0, Dividendo};
          b       <= Divisor;
          // Quotient fits in N bits only if the high half is below the
          // divisor; this also catches Divisor == 0.
          ovf     <= (Dividendo[2*N-1:N] >= Divisor);
          counter <= '0;
        end
        SHIFT: begin
          rq <= {rq[2*N-1:0], 1'b0};
        end
        SUB: begin
          if (step_ge) rq <= {step_diff, rq[N-1:1], 1'b1};
          counter <= counter + 6'd1;
        end
        DONE: begin
          if (ovf) begin
            Quociente <= FILL;
            Resto     <= FILL;
            Erro      <= 1'b1;
          end else begin
            Quociente <= rq[N-1:0];
            Resto     <= rq[2*N-1:N];
            Erro      <= 1'b0;
          end
          Pronto <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial: directed frames plus random
// operands, checked against an arithmetic reference (a / b, a % b).
module tb_divisor_sequencial;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Sy;
  logic [31:0] Dividendo;
  logic [15:0] Divisor;
  logic [15:0] Quociente;
  logic [15:0] Resto;
  logic        Erro;
  logic        Pronto;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Outputs the DUT should currently be holding.
  logic [15:0] cur_q = '0;
  logic [15:0] cur_r = '0;
  logic        cur_e = 1'b0;

  divisor_sequencial #(
    .N(16)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Sy        (Sy),
    .Dividendo (Dividendo),
    .Divisor   (Divisor),
    .Quociente (Quociente),
    .Resto     (Resto),
    .Erro      (Erro),
    .Pronto    (Pronto)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_pronto"}, 64'(Pronto), 64'(0));
    check({tag, "_hold"}, 64'({Quociente, Resto, Erro}), 64'({cur_q, cur_r, cur_e}));
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [15:0] d,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic e);
    logic [63:0] qq;
    q  = '1;
    r  = '1;
    e  = 1'b1;
    qq = '0;
    if (d != 16'd0) begin
      qq = 64'(a) / 64'(d);
      if (qq <= 64'hFFFF) begin
        q = qq[15:0];
        r = 16'(64'(a) % 64'(d));
        e = 1'b0;
      end
    end
  endfunction

  // Call with the DUT in LOAD (next edge latches the operands).
  task automatic frame(input string tag, input logic [31:0] a, input logic [15:0] d,
                       input bit drop_sy, input bit mutate);
    logic [15:0] eq, er;
    logic        ee;
    ref_div(a, d, eq, er, ee);
    Dividendo = a;
    Divisor   = d;
    tick();
    if (drop_sy) Sy = 1'b0;
    check_hold({tag, "_el"});
    for (int i = 1; i <= 32; i++) begin
      if (mutate && i == 15) begin
        Dividendo = $urandom;
        Divisor   = 16'($urandom);
      end
      tick();
      check_hold(tag);
    end
    tick();
    cur_q = eq;
    cur_r = er;
    cur_e = ee;
    check({tag, "_pronto_hi"}, 64'(Pronto), 64'(1));
    check({tag, "_q"}, 64'(Quociente), 64'(eq));
    check({tag, "_r"}, 64'(Resto), 64'(er));
    check({tag, "_erro"}, 64'(Erro), 64'(ee));
  endtask

  task automatic rand_ops(output logic [31:0] a, output logic [15:0] d);
    int unsigned mode;
    logic [15:0] hi;
    mode = $urandom_range(0, 9);
    d    = 16'($urandom);
    if (mode == 0) begin
      d = '0;
      a = $urandom;
    end else if (mode == 1) begin
      a = $urandom;
    end else begin
      hi = (d == 16'd0) ? 16'd0 : 16'($urandom_range(0, int'(d) - 1));
      a  = {hi, 16'($urandom)};
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [15:0] rd;

    Reset     = 1'b1;
    Sy        = 1'b0;
    Dividendo = '0;
    Divisor   = '0;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_q", 64'(Quociente), 64'(0));
    check("rst_r", 64'(Resto), 64'(0));
    check("rst_erro", 64'(Erro), 64'(0));
    check("rst_pronto", 64'(Pronto), 64'(0));
    for (int i = 0; i < 10; i++) begin
      tick();
      check_hold("idle");
    end

    // Sy held from here through the random frames.
    Sy        = 1'b1;
    Dividendo = 32'd900;
    Divisor   = 16'd75;
    tick();
    check_hold("start");
    frame("f900", 32'd900, 16'd75, 1'b0, 1'b0);
    frame("f83", 32'd83, 16'd16, 1'b0, 1'b0);
    frame("fmax", 32'hFFFE0001, 16'hFFFF, 1'b0, 1'b0);
    frame("f7a", 32'h007A2976, 16'h07D1, 1'b0, 1'b0);
    frame("div0", 32'd1234, 16'd0, 1'b0, 1'b0);
    frame("ovf", 32'h00100000, 16'h0010, 1'b0, 1'b0);
    frame("edge", 32'h000FFFFF, 16'h0010, 1'b0, 1'b0);
    frame("mut", 32'h00123456, 16'h1234, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      rand_ops(ra, rd);
      frame("rnd", ra, rd, 1'b0, (k % 4) == 3);
    end

    // Reset at counter = 8 aborts the frame.
    rand_ops(ra, rd);
    Dividendo = ra;
    Divisor   = rd;
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      check_hold("pre_abort");
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Sy    = 1'b0;
    cur_q = '0;
    cur_r = '0;
    cur_e = 1'b0;
    check_hold("abort");
    for (int i = 0; i < 40; i++) begin
      tick();
      check_hold("post_abort");
    end

    // Sy dropped right after LOAD: frame completes, then idles.
    Sy = 1'b1;
    tick();
    frame("drop", 32'h00ABCDEF, 16'h0ABC, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick();
      check_hold("post_drop");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/divisor_sequencial.md
Name: divisor_sequencial

Overview:
Sequential restoring divider: 32-bit Dividendo by 16-bit Divisor, giving a 16-bit Quociente and a 16-bit Resto. It is the inverse datapath of the shift-add multiplier: a Produto from the multiplier, divided by one of its factors, returns the other factor.
It uses the same Sy-gated free-running frame style as the multiplier, so both share a control scheme and a bench can chain them back to back.
It sits beside the multiplier in the MIPS ALU, serving the div/divu path (unsigned only).

Parameters:
N, 16, operand/result width; Dividendo is 2N bits wide.

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
Sy  in  1  start/synchronization level; while high, frames run back to back
Dividendo  in  2N  dividend, sampled at the edge that ends the LOAD cycle
Divisor  in  N  divisor, sampled at the same edge
Quociente  out  N  registered quotient of the last completed frame
Resto  out  N  registered remainder of the last completed frame
Erro  out  1  registered; 1 = last frame overflowed or divided by zero
Pronto  out  1  one-cycle pulse; high in the cycle after new results are written

Behaviour:
- Clock and reset: one clock (Clk); Reset is synchronous and active-high, sampled on rising Clk.
- Reset values:
  - Control: state=IDLE, counter=0.
  - Outputs: Quociente=0, Resto=0, Erro=0, Pronto=0.
  - Internal registers: RQ (2N+1 bits: carry, R[N-1:0], Q[N-1:0]), B, ovf all cleared.
  - Reset mid-frame aborts the frame: no output update, no Pronto.
- States (3-bit): IDLE, LOAD, SHIFT, SUB, DONE. Counter is 6 bits.
- Transitions:
  - IDLE→LOAD when Sy=1 at the edge; otherwise stay in IDLE.
  - LOAD edge:
    - RQ={1'b0, Dividendo}, B=Divisor.
    - ovf=(Dividendo[2N-1:N] >= Divisor); this includes Divisor=0.
    - counter=0, →SHIFT.
  - SHIFT edge: RQ = RQ<<1 (bit 0 = 0), →SUB.
  - SUB edge:
    - If RQ[2N:N] >= {0,B}: RQ[2N:N] = RQ[2N:N]-B and RQ[0]=1; otherwise RQ is unchanged.
    - counter+1. If counter was N-1, →DONE; else →SHIFT.
  - DONE edge:
    - Normal case: Quociente=RQ[N-1:0], Resto=RQ[2N-1:N], Erro=0.
    - If ovf=1: Quociente={N{1}}, Resto={N{1}}, Erro=1.
    - Pronto=1.
    - Next state is LOAD if Sy=1, else IDLE.
  - Pronto clears on the next edge (one-cycle pulse).
- Latency:
  - Operands are latched at edge E_L, the LOAD→SHIFT edge.
  - Results are written at edge E_L+33, and Pronto is high during the cycle that follows.
  - Frame length with Sy held is 34 cycles (LOAD + 16×(SHIFT,SUB) + DONE).
- Boundary conditions:
  - Operand changes outside the LOAD edge are ignored; the latched copies are used.
  - Sy falling mid-frame: the frame completes, then the block goes to IDLE.
  - Sy rising during a frame has no effect until DONE.
  - Outputs hold their last values between DONE edges and never show intermediate values.
  - Arithmetic is unsigned only. The restoring compare uses N+1 bits so the shifted-out carry is not lost.

Decomposition:
- Package divisor_pkg holds:
  - N default;
  - state encodings IDLE=0, LOAD=1, SHIFT=2, SUB=3, DONE=4;
  - ITER=N;
  - the overflow fill value {N{1}}.
- One natural sub-module: divisor_passo, a combinational N+1-bit trial subtract. It takes the remainder half and B, and returns the difference and a ge flag. It is instantiated once inside divisor_sequencial.

Test Plan:
1. Reset=1 for 2 cycles with Sy=0 → Quociente=0, Resto=0, Erro=0, Pronto=0; state stays IDLE for 10 idle cycles.
2. Sy=1, Dividendo=900, Divisor=75 at LOAD → 33 edges after E_L: Quociente=12, Resto=0, Erro=0. Pronto is high exactly one cycle, and not before.
3. Sy held high, back-to-back frames:
   - frame 1: Dividendo=83, Divisor=16 → Q=5, R=3;
   - frame 2: Dividendo=32'hFFFE0001, Divisor=16'hFFFF → Q=16'hFFFF, R=0;
   - frame 3: Dividendo=32'h007A2976, Divisor=16'h07D1 → Q=16'h0FA1, R=5;
   - frames are spaced 34 cycles apart.
4. Divisor=0, Dividendo=1234 → Erro=1, Q=16'hFFFF, R=16'hFFFF.
   Dividendo=32'h00100000, Divisor=16'h0010 → Erro=1, same fill.
   Dividendo=32'h000FFFFF, Divisor=16'h0010 → Erro=0, Q=16'hFFFF, R=16'hF.
5. Change Dividendo/Divisor mid-frame (counter=7) → result matches the values latched at LOAD.
6. Reset pulse at counter=8, then Sy dropped mid-frame in a later frame:
   - the reset returns the block to IDLE with outputs 0 and no Pronto;
   - the later frame completes normally, then the block sits in IDLE with no further Pronto.
